// File: rtl/shift_engine_if.sv
// shift_engine_if: control, data and status bundle for shift_engine.
// master drives load/start/command fields; slave is the shift engine.
interface shift_engine_if #(
   parameter int W = 8
);
   localparam int CW = $clog2(W + 1);

   logic          clr;
   logic          ld;
   logic [W-1:0]  d;
   logic          start;
   logic [2:0]    op;
   logic [CW-1:0] amt;
   logic          ser_in;
   logic [W-1:0]  q;
   logic          ser_out;
   logic          busy;
   logic          done;

   modport master (
      output clr, ld, d, start, op, amt, ser_in,
      input  q, ser_out, busy, done
   );

   modport slave (
      input  clr, ld, d, start, op, amt, ser_in,
      output q, ser_out, busy, done
   );
endinterface

// File: rtl/shift_engine.sv
// shift_engine: W-bit parallel-load shift/rotate register with an IDLE/RUN
// sequencer, busy/done handshake and a registered serial output tap.
// Optional macro SHIFT_ENGINE_BARREL_EN: the whole shift is applied in a
// single RUN edge instead of one position per edge.
module shift_engine #(
   parameter int W = 8
) (
   input logic           clk,
   input logic           rst,
   shift_engine_if.slave bus
);
   localparam int CW = $clog2(W + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  q_r, q_nxt;
   logic          ser_r, ser_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    op_r, op_nxt;
   logic          done_r, done_nxt;
   logic [CW-1:0] amt_eff;
   logic [W:0]    acc;

   // One single-position step; result is {exited bit, new register value}.
   // Reserved codes keep both the register and the serial tap.
   function automatic logic [W:0] step(input logic [W-1:0] v, input logic [2:0] o,
                                       input logic fill, input logic so);
      logic [W:0] r;
      case (o)
         3'b000:  r = {v[W-1], v[W-2:0], fill};
         3'b001:  r = {v[0], fill, v[W-1:1]};
         3'b010:  r = {v[W-1], v[W-2:0], v[W-1]};
         3'b011:  r = {v[0], v[0], v[W-1:1]};
         3'b100:  r = {v[0], v[W-1], v[W-1:1]};
         3'b101:  r = {v[W-1], v[W-2:0], 1'b0};
         default: r = {so, v};
      endcase
      return r;
   endfunction

   assign amt_eff = (bus.amt > CW'(W)) ? CW'(W) : bus.amt;

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath, count, latched op and done pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r    <= '0;
         ser_r  <= 1'b0;
         cnt    <= '0;
         op_r   <= '0;
         done_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         ser_r  <= ser_nxt;
         cnt    <= cnt_nxt;
         op_r   <= op_nxt;
         done_r <= done_nxt;
      end
   end

   // Next-state and next-datapath decode: clr > ld > start > shift step.
   always_comb begin
      state_nxt = state;
      q_nxt     = q_r;
      ser_nxt   = ser_r;
      cnt_nxt   = cnt;
      op_nxt    = op_r;
      done_nxt  = 1'b0;
      acc       = {ser_r, q_r};
      if (bus.clr) begin
         state_nxt = IDLE;
         q_nxt     = '0;
         ser_nxt   = 1'b0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ld) begin
                  q_nxt = bus.d;
               end else if (bus.start) begin
                  op_nxt = bus.op;
                  if (amt_eff == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     state_nxt = RUN;
                     cnt_nxt   = amt_eff;
                  end
               end
            end
            RUN: begin
`ifdef SHIFT_ENGINE_BARREL_EN
               // Chain cnt single steps combinationally so q and ser_out
               // match the stepwise result exactly.
               for (int unsigned i = 0; i < W; i++) begin
                  if (i < 32'(cnt)) acc = step(acc[W-1:0], op_r, bus.ser_in, acc[W]);
               end
               {ser_nxt, q_nxt} = acc;
               cnt_nxt   = '0;
               state_nxt = IDLE;
               done_nxt  = 1'b1;
`else
               acc              = step(q_r, op_r, bus.ser_in, ser_r);
               {ser_nxt, q_nxt} = acc;
               cnt_nxt          = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
`endif
            end
         endcase
      end
   end

   assign bus.q       = q_r;
   assign bus.ser_out = ser_r;
   assign bus.busy    = (state == RUN);
   assign bus.done    = done_r;
endmodule
